// File: rtl/result_bcd_converter_pkg.sv
// Shared definitions for the result-to-BCD converter: FSM state encoding
// and the double-dabble add-3 threshold.
package result_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_adjust_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries cleanly into the next digit.
module bcd_adjust_digit
    import result_bcd_converter_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= ADD3_THRESHOLD) ? d + 4'd3 : d;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter from the add/sub result to sign plus
// hundreds/tens/ones BCD digits; digit outputs only update on completion.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] S,
    input  logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic             ovf,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    mag;
    logic [WIDTH-1:0]    mag_next;
    logic [4*DIGITS-1:0] work;
    logic [4*DIGITS-1:0] work_adj;
    logic [4*DIGITS-1:0] work_next;
    logic                accept;
    logic                last_shift;

    // A new operand is taken whenever the converter is not mid-shift.
    assign accept     = start && (state != SHIFT);
    assign last_shift = (state == SHIFT) && (count == CW'(WIDTH - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_adjust_digit u_adjust (
            .d(work[4*g +: 4]),
            .q(work_adj[4*g +: 4])
        );
    end

    assign {work_next, mag_next} = {work_adj, mag} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = start ? SHIFT : IDLE;
            SHIFT:      if (last_shift) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Negative signed operands are converted as their magnitude, so 8'h80 reads as 128.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign  <= 1'b0;
            ovf   <= 1'b0;
            mag   <= '0;
            work  <= '0;
            count <= '0;
            bcd2  <= 4'd0;
            bcd1  <= 4'd0;
            bcd0  <= 4'd0;
        end else if (accept) begin
            sign  <= signed_en && S[WIDTH-1];
            ovf   <= overflow;
            mag   <= (signed_en && S[WIDTH-1]) ? (~S + WIDTH'(1)) : S;
            work  <= '0;
            count <= '0;
        end else if (state == SHIFT) begin
            work  <= work_next;
            mag   <= mag_next;
            count <= count + CW'(1);
            if (last_shift) begin
                bcd2 <= work_next[8 +: 4];
                bcd1 <= work_next[4 +: 4];
                bcd0 <= work_next[0 +: 4];
            end
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: stimulus pushes arithmetic
// expectations, an independent monitor pops them on every done pulse.
module tb_result_bcd_converter;

    typedef struct {
        logic       sign;
        logic       ovf;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       signed_en;
    logic [7:0] S;
    logic       overflow;
    logic       busy;
    logic       done;
    logic       sign;
    logic       ovf;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    result_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_en(signed_en),
        .S(S),
        .overflow(overflow),
        .busy(busy),
        .done(done),
        .sign(sign),
        .ovf(ovf),
        .bcd2(bcd2),
        .bcd1(bcd1),
        .bcd0(bcd0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: decimal digits of the displayed magnitude by plain arithmetic.
    function automatic exp_t model(input logic se, input logic [7:0] s, input logic of);
        exp_t e;
        int   val;
        e.sign = se && (s >= 8'd128);
        val    = e.sign ? 256 - int'(s) : int'(s);
        e.ovf  = of;
        e.d2   = 4'(val / 100);
        e.d1   = 4'((val / 10) % 10);
        e.d0   = 4'(val % 10);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one operand with a single-cycle start; returns just after the accepting edge.
    task automatic applyStimulus(input logic se, input logic [7:0] s, input logic of);
        @(negedge clk);
        signed_en = se;
        S         = s;
        overflow  = of;
        start     = 1'b1;
        @(posedge clk);
        sb.push_back(model(se, s, of));
        #1 start = 1'b0;
    endtask

    // Counts busy cycles up to the done pulse, bounded so the bench cannot hang.
    task automatic checkOutput(input string name, input int exp_busy);
        int busy_cycles = 0;
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) busy_cycles++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    endtask

    // Monitor: pops on done, and checks digits never move between done pulses.
    initial begin : monitor
        exp_t       e;
        logic [11:0] last_digits;
        logic        prev_done;
        last_digits = 12'h000;
        prev_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_digits = 12'h000;
                prev_done   = 1'b0;
            end else if (done) begin
                check("single_pulse", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sign", 32'(sign), 32'(e.sign));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("digits", {20'd0, bcd2, bcd1, bcd0}, {20'd0, e.d2, e.d1, e.d0});
                    last_digits = {e.d2, e.d1, e.d0};
                end
                prev_done = 1'b1;
            end else begin
                check("digits_stable", {20'd0, bcd2, bcd1, bcd0}, {20'd0, last_digits});
                prev_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst       = 1'b1;
        start     = 1'b0;
        signed_en = 1'b0;
        S         = 8'h00;
        overflow  = 1'b0;
        #12;
        check("reset_state", {24'd0, busy, done, sign, ovf, bcd2}, 32'd0);
        check("reset_digits", {24'd0, bcd1, bcd0}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases: unsigned max, signed extremes, overflow latch.
        applyStimulus(1'b0, 8'hFF, 1'b0);
        checkOutput("unsigned_ff", 8);
        applyStimulus(1'b1, 8'h80, 1'b0);
        checkOutput("signed_80", 8);
        applyStimulus(1'b1, 8'hF6, 1'b0);
        checkOutput("signed_f6", 8);
        applyStimulus(1'b0, 8'hF6, 1'b0);
        checkOutput("unsigned_f6", 8);
        applyStimulus(1'b1, 8'h7F, 1'b1);
        checkOutput("ovf_set", 8);
        applyStimulus(1'b1, 8'h7F, 1'b0);
        checkOutput("ovf_clear", 8);

        // Start re-asserted at E3 while busy must be ignored.
        applyStimulus(1'b0, 8'd42, 1'b0);
        repeat (3) @(negedge clk);
        S     = 8'd199;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("start_ignored", 5);
        repeat (6) @(negedge clk);

        // Reset in the middle of a conversion aborts it.
        applyStimulus(1'b0, 8'h63, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ctrl", {28'd0, busy, done, sign, ovf}, 32'd0);
        check("abort_digits", {20'd0, bcd2, bcd1, bcd0}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("after_abort", 8);

        // Start held through DONE starts the next conversion immediately.
        @(negedge clk);
        signed_en = 1'b1;
        S         = 8'd77;
        overflow  = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        sb.push_back(model(1'b1, 8'd77, 1'b0));
        #1 S = 8'hC8;
        overflow = 1'b1;
        checkOutput("held_first", 8);
        sb.push_back(model(1'b1, 8'hC8, 1'b1));
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("held_second", 8);

        // Randomised operands with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 1'($urandom));
            checkOutput("random", 8);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
